// File: rtl/arm_mc_pkg.sv
// Shared types and mux encodings for the multicycle ARM controller and datapath.
package arm_mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StUnknown
   } statetype;

   // alu_src_b select encodings
   localparam logic [1:0] SRCB_RD2    = 2'b00;
   localparam logic [1:0] SRCB_EXTIMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // result_src select encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_retire_ctr.sv
// Retired-instruction counter: increments on enable, wraps naturally, async clear.
module mc_retire_ctr #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Count completed instructions; all-ones rolls over to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/mc_mainfsm.sv
// Main sequencing FSM of the multicycle ARMv4-subset core.
module mc_mainfsm
   import arm_mc_pkg::*;
#(
   parameter int unsigned RET_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       op,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             ir_write,
   output logic             next_pc,
   output logic             adr_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       result_src,
   output logic             alu_op,
   output logic             reg_w,
   output logic             mem_w,
   output logic             branch,
   output logic             illegal,
   output logic [RET_W-1:0] retired
);

   statetype state_q, state_d;
   logic     retire;

   // Only the I bit and the L bit of funct steer sequencing.
   logic unused_funct_bits;
   assign unused_funct_bits = ^funct[4:1];

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, per-state control word and retire strobe.
   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      ir_write   = 1'b0;
      next_pc    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RD2;
      result_src = RES_ALUOUT;
      alu_op     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b0;
      unique case (state_q)
         StFetch: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ready;
            next_pc    = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            // PC+8 is presented here so R15 reads see the architectural value.
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            unique case (op)
               2'b00: state_d = funct[5] ? StExecI : StExecR;
               2'b01: state_d = StMemAdr;
               2'b10: state_d = StBranch;
               2'b11: state_d = StUnknown;
            endcase
         end
         StMemAdr: begin
            alu_src_b = SRCB_EXTIMM;
            state_d   = funct[0] ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            adr_src = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            retire     = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StExecR: begin
            alu_op  = 1'b1;
            state_d = StAluWb;
         end
         StExecI: begin
            alu_src_b = SRCB_EXTIMM;
            alu_op    = 1'b1;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_w   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StBranch: begin
            alu_src_b  = SRCB_EXTIMM;
            result_src = RES_ALURESULT;
            branch     = 1'b1;
            retire     = 1'b1;
            state_d    = StFetch;
         end
         StUnknown: begin
            illegal = 1'b1;
            state_d = StFetch;
         end
         default: state_d = StFetch;
      endcase
      // Nothing may be requested while reset is held, even in the FETCH row.
      if (reset) begin
         ir_write   = 1'b0;
         next_pc    = 1'b0;
         adr_src    = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = SRCB_RD2;
         result_src = RES_ALUOUT;
         alu_op     = 1'b0;
         reg_w      = 1'b0;
         mem_w      = 1'b0;
         branch     = 1'b0;
         illegal    = 1'b0;
         retire     = 1'b0;
      end
   end

   mc_retire_ctr #(
      .WIDTH (RET_W)
   ) u_retire_ctr (
      .clk     (clk),
      .reset   (reset),
      .en_i    (retire),
      .count_o (retired)
   );

endmodule

// File: tb/tb_mc_mainfsm.sv
// Scoreboard bench for mc_mainfsm: stimulus pushes expected per-instruction behaviour,
// a monitor pops at each instruction's completing cycle and compares.
module tb_mc_mainfsm;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    op;
   logic [5:0]    funct;
   logic          mem_ready;
   logic          ir_write, next_pc, adr_src, alu_src_a, alu_op, reg_w, mem_w, branch, illegal;
   logic [1:0]    alu_src_b, result_src;
   logic [RW-1:0] retired;

   mc_mainfsm #(.RET_W(RW)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .mem_ready  (mem_ready),
      .ir_write   (ir_write),
      .next_pc    (next_pc),
      .adr_src    (adr_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .alu_op     (alu_op),
      .reg_w      (reg_w),
      .mem_w      (mem_w),
      .branch     (branch),
      .illegal    (illegal),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cycles;
      int n_irw;
      int n_pc;
      int n_regw;
      int n_memw;
      int n_br;
      int n_ill;
      int n_aluop;
      int end_res;
      int end_b;
      int ret;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   ret_model = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: instruction class, fetch waits and data waits -> observable behaviour.
   function automatic exp_t model(input logic [1:0] o, input logic [5:0] f, input int fw,
                                  input int mw);
      exp_t e;
      e = '{cycles: 0, n_irw: 1, n_pc: 1, n_regw: 0, n_memw: 0, n_br: 0, n_ill: 0,
            n_aluop: 0, end_res: 0, end_b: 0, ret: 0};
      case (o)
         2'b00: begin e.cycles = 4 + fw; e.n_regw = 1; e.n_aluop = 1; end
         2'b01: begin
            if (f[0]) begin e.cycles = 5 + fw + mw; e.n_regw = 1; e.end_res = 1; end
            else begin e.cycles = 4 + fw + mw; e.n_memw = mw + 1; end
         end
         2'b10: begin e.cycles = 3 + fw; e.n_br = 1; e.end_res = 2; e.end_b = 1; end
         default: begin e.cycles = 3 + fw; e.n_ill = 1; end
      endcase
      if (o != 2'b11) ret_model = (ret_model + 1) % (1 << RW);
      e.ret = ret_model;
      return e;
   endfunction

   task automatic step(input logic v);
      mem_ready = v;
      @(posedge clk);
      #1;
   endtask

   // Present one instruction and the memory's handshake timeline for it.
   task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int fw,
                            input int mw);
      op    = o;
      funct = f;
      q.push_back(model(o, f, fw, mw));
      repeat (fw) step(1'b0);
      step(1'b1);                       // fetch completes
      step(1'($urandom));               // decode ignores mem_ready
      case (o)
         2'b00: begin step(1'($urandom)); step(1'($urandom)); end
         2'b01: begin
            step(1'($urandom));
            repeat (mw) step(1'b0);
            step(1'b1);
            if (f[0]) step(1'($urandom));
         end
         default: step(1'($urandom));
      endcase
   endtask

   // Monitor: accumulate per-instruction strobes; the completing cycle is the one showing
   // a register write, branch, illegal pulse or accepted store.
   int   cyc, c_irw, c_pc, c_regw, c_memw, c_br, c_ill, c_aluop;
   bit   pend;
   int   pend_ret;
   exp_t e;

   task automatic clr();
      cyc = 0; c_irw = 0; c_pc = 0; c_regw = 0; c_memw = 0; c_br = 0; c_ill = 0; c_aluop = 0;
   endtask

   always @(negedge clk) begin
      if (!mon_en) begin
         clr();
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("retired", retired, pend_ret);
            pend = 1'b0;
         end
         cyc++;
         c_irw += int'(ir_write);
         c_pc += int'(next_pc);
         c_regw += int'(reg_w);
         c_memw += int'(mem_w);
         c_br += int'(branch);
         c_ill += int'(illegal);
         c_aluop += int'(alu_op);
         if (reg_w || branch || illegal || (mem_w && mem_ready)) begin
            if (q.size() == 0) begin
               chk("unexpected_completion", 1, 0);
            end else begin
               e = q.pop_front();
               chk("cycles", cyc, e.cycles);
               chk("ir_write_cycles", c_irw, e.n_irw);
               chk("next_pc_cycles", c_pc, e.n_pc);
               chk("reg_w_cycles", c_regw, e.n_regw);
               chk("mem_w_cycles", c_memw, e.n_memw);
               chk("branch_cycles", c_br, e.n_br);
               chk("illegal_cycles", c_ill, e.n_ill);
               chk("alu_op_cycles", c_aluop, e.n_aluop);
               chk("end_result_src", result_src, e.end_res);
               chk("end_alu_src_b", alu_src_b, e.end_b);
               pend     = 1'b1;
               pend_ret = e.ret;
            end
            clr();
         end else if (cyc > 100) begin
            chk("completion_timeout", cyc, 0);
            clr();
         end
      end
   end

   task automatic chk_idle(input string name);
      chk({name, "_ctl"}, {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
                           alu_op, reg_w, mem_w, branch, illegal}, 0);
      chk({name, "_retired"}, retired, 0);
   endtask

   task automatic chk_fetch(input string name);
      chk({name, "_adr_src"}, adr_src, 0);
      chk({name, "_alu_src_a"}, alu_src_a, 1);
      chk({name, "_alu_src_b"}, alu_src_b, 2);
      chk({name, "_result_src"}, result_src, 2);
      chk({name, "_ir_write"}, ir_write, mem_ready);
      chk({name, "_next_pc"}, next_pc, mem_ready);
      chk({name, "_others"}, {alu_op, reg_w, mem_w, branch, illegal}, 0);
      chk({name, "_retired"}, retired, 0);
   endtask

   initial begin
      reset     = 1'b1;
      op        = 2'b00;
      funct     = 6'd0;
      mem_ready = 1'b0;
      #1;
      chk_idle("reset_initial");
      @(posedge clk); #1;
      mem_ready = 1'b1;
      #1;
      chk_idle("reset_memready");
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk_fetch("fetch_after_reset");

      mon_en = 1'b1;
      run_instr(2'b00, 6'b101000, 0, 0);   // ADD imm 0xE2802005
      run_instr(2'b01, 6'b011001, 0, 3);   // LDR 0xE5901000, 3 wait cycles
      run_instr(2'b01, 6'b011000, 0, 2);   // STR 0xE5801000, 2 wait cycles
      run_instr(2'b10, 6'b100000, 0, 0);   // B 0xEA000001
      run_instr(2'b11, 6'b000000, 0, 0);   // unsupported op
      run_instr(2'b00, 6'b001000, 1, 0);   // ADD reg, one fetch wait
      for (int i = 0; i < 40; i++) begin
         run_instr(2'($urandom_range(0, 3)), 6'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 3));
      end
      step(1'b0);                          // lets the last retire count be observed
      chk("queue_drained", q.size(), 0);
      mon_en = 1'b0;

      // Abort an LDR while it waits in MEMREAD.
      op    = 2'b01;
      funct = 6'b011001;
      step(1'b1);
      step(1'b1);
      step(1'b1);
      mem_ready = 1'b0;
      #1;
      chk("memread_adr_src", adr_src, 1);
      chk("memread_result_src", result_src, 0);
      reset = 1'b1;
      #1;
      chk_idle("reset_in_memread");
      mem_ready = 1'b1;
      #1;
      chk_idle("reset_in_memread_ready");
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk_fetch("fetch_after_abort");

      ret_model = 0;
      mon_en    = 1'b1;
      run_instr(2'b00, 6'b101000, 0, 0);
      step(1'b0);
      chk("queue_drained_final", q.size(), 0);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
